// File: rtl/apb_rr_mem_arbiter_if.sv
// apb_rr_mem_arbiter_if
//   Groups the request-FIFO, memory and response signals of the round-robin
//   APB memory arbiter.
//   modport master : the arbiter (pops FIFOs, drives memory, returns acks)
//   modport slave  : the environment (FIFOs, memory, interconnect)
//   Signals:
//     fifo_empty/fifo_write [NUM_REQ]     per-port FIFO status / head is write
//     fifo_addr/fifo_wdata  [NUM_REQ*32]  per-port head fields, port i at [32i+:32]
//     fifo_pop              [NUM_REQ]     one-hot pop strobe
//     mem_en/mem_we/mem_addr/mem_wdata    memory request
//     mem_rdata/mem_ready                 memory completion
//     arb_rdata/arb_rdata_ack/arb_wr_ack/arb_err  response to interconnects
//     busy                                arbiter not idle
interface apb_rr_mem_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16
);
  logic [NUM_REQ-1:0]    fifo_empty;
  logic [NUM_REQ-1:0]    fifo_write;
  logic [NUM_REQ*32-1:0] fifo_addr;
  logic [NUM_REQ*32-1:0] fifo_wdata;
  logic [NUM_REQ-1:0]    fifo_pop;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_ready;
  logic [31:0]           arb_rdata;
  logic [NUM_REQ-1:0]    arb_rdata_ack;
  logic [NUM_REQ-1:0]    arb_wr_ack;
  logic                  arb_err;
  logic                  busy;

  modport master (
    input  fifo_empty, fifo_write, fifo_addr, fifo_wdata, mem_rdata, mem_ready,
    output fifo_pop, mem_en, mem_we, mem_addr, mem_wdata,
           arb_rdata, arb_rdata_ack, arb_wr_ack, arb_err, busy
  );

  modport slave (
    output fifo_empty, fifo_write, fifo_addr, fifo_wdata, mem_rdata, mem_ready,
    input  fifo_pop, mem_en, mem_we, mem_addr, mem_wdata,
           arb_rdata, arb_rdata_ack, arb_wr_ack, arb_err, busy
  );
endinterface

// File: rtl/apb_rr_mem_arbiter.sv
// apb_rr_mem_arbiter
//   Pops one request at a time from the per-port FWFT FIFOs in round-robin
//   order, runs the access on the shared single-port memory with a ready
//   handshake and timeout, then returns a one-cycle ack, read data and an
//   error flag to the originating port.
//   Ports:
//     PCLK    clock, rising edge
//     PRESET  synchronous active-low reset
//     bus_io  FIFO / memory / response signals (master side)
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | pick next non-empty port, pop it and latch its head entry
//   S_ACCESS | memory request held until mem_ready or timeout
//   S_RESP   | one-cycle ack pulse to the granted port
module apb_rr_mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  apb_rr_mem_arbiter_if.master bus_io
);
  localparam int LG_W = $clog2(NUM_REQ);
  localparam int WC_W = $clog2(TIMEOUT);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);
  localparam logic [LG_W-1:0] LG_RST  = LG_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [LG_W-1:0]   last_grant_q, last_grant_d;
  logic [LG_W-1:0]   grant_q, grant_d;
  logic              lat_write_q, lat_write_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [31:0]       lat_wdata_q, lat_wdata_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
  logic [31:0]       arb_rdata_q, arb_rdata_d;

  // Round-robin search starting one past the last served port.
  logic              req_any;
  logic [LG_W-1:0]   sel_idx;
  logic              sel_write;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_oor;
  int                idx;

  always_comb begin
    req_any = 1'b0;
    sel_idx = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!req_any && !bus_io.fifo_empty[LG_W'(idx)]) begin
        req_any = 1'b1;
        sel_idx = LG_W'(idx);
      end
    end
  end

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == LG_W'(i)) begin
        sel_write = bus_io.fifo_write[i];
        sel_addr  = bus_io.fifo_addr[32*i +: 32];
        sel_wdata = bus_io.fifo_wdata[32*i +: 32];
      end
    end
  end

  assign sel_oor = (sel_addr >> ADDR_W) != 32'd0;

  always_ff @(posedge PCLK) begin
    if (!PRESET) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      last_grant_q <= LG_RST;
      grant_q      <= '0;
      lat_write_q  <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      wait_cnt_q   <= '0;
      err_q        <= 1'b0;
      arb_rdata_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      lat_write_q  <= lat_write_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      wait_cnt_q   <= wait_cnt_d;
      err_q        <= err_d;
      arb_rdata_q  <= arb_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    lat_write_d  = lat_write_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    wait_cnt_d   = wait_cnt_q;
    err_d        = err_q;
    arb_rdata_d  = arb_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          grant_d     = sel_idx;
          lat_write_d = sel_write;
          lat_addr_d  = sel_addr[ADDR_W-1:0];
          lat_wdata_d = sel_wdata;
          wait_cnt_d  = '0;
          // Out-of-range addresses are answered with an error, never touching memory.
          if (sel_oor) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (bus_io.mem_ready) begin
          if (!lat_write_q) arb_rdata_d = bus_io.mem_rdata;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (wait_cnt_q == WC_LAST) begin
          err_d       = 1'b1;
          arb_rdata_d = 32'hDEAD_BEEF;
          state_d     = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [NUM_REQ-1:0] grant_oh;
  assign grant_oh = NUM_REQ'(1) << grant_q;

  always_comb begin
    bus_io.fifo_pop      = '0;
    bus_io.mem_en        = 1'b0;
    bus_io.mem_we        = 1'b0;
    bus_io.mem_addr      = '0;
    bus_io.mem_wdata     = '0;
    bus_io.arb_rdata_ack = '0;
    bus_io.arb_wr_ack    = '0;
    bus_io.arb_err       = 1'b0;
    bus_io.busy          = (state_q != S_IDLE);
    bus_io.arb_rdata     = arb_rdata_q;
    case (state_q)
      // A pop while reset is low would discard the entry without latching it.
      S_IDLE: if (req_any && PRESET) bus_io.fifo_pop = NUM_REQ'(1) << sel_idx;
      S_ACCESS: begin
        bus_io.mem_en    = 1'b1;
        bus_io.mem_we    = lat_write_q;
        bus_io.mem_addr  = lat_addr_q;
        bus_io.mem_wdata = lat_wdata_q;
      end
      S_RESP: begin
        if (lat_write_q) bus_io.arb_wr_ack    = grant_oh;
        else             bus_io.arb_rdata_ack = grant_oh;
        bus_io.arb_err = err_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_apb_rr_mem_arbiter.sv
module tb_apb_rr_mem_arbiter;
  localparam int NR   = 4;
  localparam int AW   = 16;
  localparam int TO   = 16;
  localparam int LOGN = 8192;

  logic PCLK   = 1'b0;
  logic PRESET = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_rr_mem_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW)) bus ();
  apb_rr_mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .bus_io(bus)
  );

  // One FIFO entry plus the memory behaviour it will see: w = cycles of
  // mem_ready=0 before completion, rdata = data returned on completion.
  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  w;
    logic [31:0] rdata;
  } ent_t;

  ent_t fq [NR][$];
  int checks = 0, errors = 0, cyc = -1;

  // Transaction-level model: a popped entry has a fixed timeline.
  bit          active = 0, oor = 0, tmo = 0;
  ent_t        cur;
  int          cur_port = 0, t_pop = 0, nmem = 0, ack_cyc = 0;
  int          last_port = NR - 1;
  logic [31:0] hold = '0;
  logic        rst_n_next = 1'b0;

  logic [NR-1:0] e_pop = '0, e_rack = '0, e_wack = '0;
  logic          e_en = 0, e_we = 0, e_err = 0, e_busy = 0;
  logic [AW-1:0] e_addr = '0;
  logic [31:0]   e_wdata = '0, e_rdata = '0;

  logic [NR-1:0] pop_log [LOGN];
  logic [NR-1:0] rack_log [LOGN];
  logic [NR-1:0] wack_log [LOGN];
  logic          en_log [LOGN];
  logic          we_log [LOGN];
  logic          err_log [LOGN];
  logic          busy_log [LOGN];
  logic [AW-1:0] addr_log [LOGN];
  logic [31:0]   rd_log [LOGN];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp_v);
    end
  endtask

  function automatic ent_t mk(logic wr, logic [31:0] a, logic [31:0] wd, logic [7:0] w, logic [31:0] rd);
    ent_t e;
    e.wr = wr; e.addr = a; e.wdata = wd; e.w = w; e.rdata = rd;
    return e;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < NR; i++) if (fq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    int p;
    @(posedge PCLK);
    if (!PRESET) begin
      active = 0; last_port = NR - 1; hold = '0;
    end else if (active && cyc == ack_cyc) begin
      active = 0; last_port = cur_port;
    end
    #1;
    cyc++;
    PRESET = rst_n_next;
    for (int i = 0; i < NR; i++) begin
      bus.fifo_empty[i] = (fq[i].size() == 0);
      if (fq[i].size() != 0) begin
        bus.fifo_write[i]          = fq[i][0].wr;
        bus.fifo_addr[32*i +: 32]  = fq[i][0].addr;
        bus.fifo_wdata[32*i +: 32] = fq[i][0].wdata;
      end else begin
        bus.fifo_write[i]          = 1'($urandom_range(0, 1));
        bus.fifo_addr[32*i +: 32]  = $urandom;
        bus.fifo_wdata[32*i +: 32] = $urandom;
      end
    end
    e_pop = '0; e_rack = '0; e_wack = '0; e_en = 0; e_we = 0; e_err = 0;
    e_addr = '0; e_wdata = '0;
    if (!active && PRESET) begin
      for (int k = 1; k <= NR; k++) begin
        p = (last_port + k) % NR;
        if (!active && fq[p].size() != 0) begin
          cur = fq[p].pop_front();
          cur_port = p; active = 1; t_pop = cyc;
          oor = (cur.addr >> AW) != 0;
          tmo = !oor && (int'(cur.w) >= TO);
          nmem = oor ? 0 : (tmo ? TO : int'(cur.w) + 1);
          ack_cyc = cyc + nmem + 1;
          e_pop[p] = 1'b1;
        end
      end
    end
    if (active && cyc > t_pop && cyc <= t_pop + nmem) begin
      e_en = 1; e_we = cur.wr; e_addr = cur.addr[AW-1:0]; e_wdata = cur.wdata;
      bus.mem_ready = (cyc - t_pop - 1 == int'(cur.w));
      bus.mem_rdata = bus.mem_ready ? cur.rdata : $urandom;
    end else begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.mem_rdata = $urandom;
    end
    if (active && cyc == ack_cyc) begin
      if (cur.wr) e_wack[cur_port] = 1'b1;
      else        e_rack[cur_port] = 1'b1;
      e_err = oor || tmo;
      if (tmo) hold = 32'hDEAD_BEEF;
      else if (!oor && !cur.wr) hold = cur.rdata;
    end
    e_busy  = active && cyc > t_pop;
    e_rdata = hold;
  endtask

  always @(negedge PCLK) begin
    if (cyc >= 0) begin
      cmp("fifo_pop",      32'(bus.fifo_pop),      32'(e_pop));
      cmp("mem_en",        32'(bus.mem_en),        32'(e_en));
      cmp("mem_we",        32'(bus.mem_we),        32'(e_we));
      cmp("mem_addr",      32'(bus.mem_addr),      32'(e_addr));
      cmp("mem_wdata",     bus.mem_wdata,          e_wdata);
      cmp("arb_rdata_ack", 32'(bus.arb_rdata_ack), 32'(e_rack));
      cmp("arb_wr_ack",    32'(bus.arb_wr_ack),    32'(e_wack));
      cmp("arb_err",       32'(bus.arb_err),       32'(e_err));
      cmp("busy",          32'(bus.busy),          32'(e_busy));
      cmp("arb_rdata",     bus.arb_rdata,          e_rdata);
      if (cyc < LOGN) begin
        pop_log[cyc]  = bus.fifo_pop;      rack_log[cyc] = bus.arb_rdata_ack;
        wack_log[cyc] = bus.arb_wr_ack;    en_log[cyc]   = bus.mem_en;
        we_log[cyc]   = bus.mem_we;        err_log[cyc]  = bus.arb_err;
        busy_log[cyc] = bus.busy;          addr_log[cyc] = bus.mem_addr;
        rd_log[cyc]   = bus.arb_rdata;
      end
    end
  end

  task automatic run_idle(input int budget);
    int n = 0;
    do begin tick(); n++; end while ((active || pending()) && n < budget);
    if (active || pending()) begin
      checks++; errors++;
      $display("FAIL run_idle: budget of %0d cycles expired, got busy expected idle", budget);
    end
    @(negedge PCLK); #1;
  endtask

  task automatic rst_cycles(input int n);
    rst_n_next = 1'b0;
    repeat (n) tick();
    rst_n_next = 1'b1;
  endtask

  function automatic ent_t rnd_ent();
    int r;
    logic [31:0] a;
    logic [7:0]  w;
    r = $urandom_range(0, 19);
    if (r < 10)      w = 8'd0;
    else if (r < 17) w = 8'($urandom_range(1, 5));
    else             w = 8'($urandom_range(TO - 1, TO + 2));
    if ($urandom_range(0, 7) == 0) a = {16'($urandom_range(1, 65535)), 16'($urandom)};
    else                           a = {16'h0, 16'($urandom)};
    return mk(1'($urandom_range(0, 1)), a, $urandom, w, $urandom);
  endfunction

  int c1, c2, c3, c4, c5, c6, c7, cnt;

  initial begin
    bus.fifo_empty = '1; bus.fifo_write = '0; bus.fifo_addr = '0; bus.fifo_wdata = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;

    rst_cycles(3);
    push_one(1, mk(1'b0, 32'h0000_0010, 32'h0, 8'd0, 32'hA5A5_0001));
    c1 = cyc + 1;
    run_idle(50);
    cmp("reset_busy",      32'(busy_log[c1-1]), 32'd0);
    cmp("reset_rdata",     rd_log[c1-1], 32'd0);
    cmp("rd_pop",          32'(pop_log[c1]), 32'b0010);
    cmp("rd_mem_en",       32'(en_log[c1+1]), 32'd1);
    cmp("rd_mem_we",       32'(we_log[c1+1]), 32'd0);
    cmp("rd_mem_addr",     32'(addr_log[c1+1]), 32'h0010);
    cmp("rd_ack",          32'(rack_log[c1+2]), 32'b0010);
    cmp("rd_data",         rd_log[c1+2], 32'hA5A5_0001);

    rst_cycles(2);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) push_one(i, mk(1'b0, 32'($urandom_range(0, 65535)), 32'h0, 8'd0, $urandom));
    c2 = cyc + 1;
    run_idle(100);
    for (int k = 0; k < 8; k++) cmp("rr_order", 32'(pop_log[c2 + 3*k]), 32'(1) << (k % 4));
    cmp("rr_gap", 32'(pop_log[c2 + 1]) | 32'(pop_log[c2 + 2]), 32'd0);

    push_one(0, mk(1'b1, 32'h40, 32'h1, 8'd0, 32'h0));
    run_idle(20);
    push_one(0, mk(1'b0, 32'h44, 32'h0, 8'd1, 32'h1111_2222));
    push_one(2, mk(1'b1, 32'h48, 32'h2, 8'd0, 32'h0));
    c3 = cyc + 1;
    run_idle(40);
    cmp("rr_skip_first",  32'(pop_log[c3]), 32'b0100);
    cmp("rr_skip_second", 32'(pop_log[c3 + 3]), 32'b0001);

    push_one(3, mk(1'b1, 32'h0001_0000, 32'h1234_5678, 8'd0, 32'h0));
    c4 = cyc + 1;
    run_idle(20);
    cmp("oor_pop",    32'(pop_log[c4]), 32'b1000);
    cmp("oor_wr_ack", 32'(wack_log[c4+1]), 32'b1000);
    cmp("oor_err",    32'(err_log[c4+1]), 32'd1);
    cmp("oor_mem_en", 32'(en_log[c4+1]), 32'd0);

    push_one(0, mk(1'b0, 32'h20, 32'h0, 8'd255, 32'h0));
    c5 = cyc + 1;
    run_idle(60);
    cnt = 0;
    for (int k = 1; k <= 17; k++) cnt += int'(en_log[c5 + k]);
    cmp("tmo_en_cycles", 32'(cnt), 32'd16);
    cmp("tmo_ack",   32'(rack_log[c5+17]), 32'b0001);
    cmp("tmo_err",   32'(err_log[c5+17]), 32'd1);
    cmp("tmo_rdata", rd_log[c5+17], 32'hDEAD_BEEF);

    push_one(2, mk(1'b0, 32'h30, 32'h0, 8'd40, 32'h0));
    c6 = cyc + 1;
    repeat (4) tick();
    rst_n_next = 1'b0;
    tick();
    rst_n_next = 1'b1;
    tick();
    push_one(0, mk(1'b0, 32'h50, 32'h0, 8'd0, 32'h5));
    push_one(1, mk(1'b0, 32'h54, 32'h0, 8'd0, 32'h6));
    c7 = cyc + 1;
    run_idle(40);
    cmp("abort_was_access", 32'(en_log[c6+3]), 32'd1);
    cmp("abort_mem_en",     32'(en_log[c6+5]), 32'd0);
    cmp("abort_busy",       32'(busy_log[c6+5]), 32'd0);
    cmp("abort_rdata",      rd_log[c6+5], 32'd0);
    cmp("abort_ack",        32'(rack_log[c6+5]) | 32'(wack_log[c6+5]), 32'd0);
    cmp("abort_prio",       32'(pop_log[c7]), 32'b0001);

    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NR; i++)
        if ($urandom_range(0, 3) == 0 && fq[i].size() < 4) push_one(i, rnd_ent());
      if (rst_n_next == 1'b0) rst_n_next = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst_n_next = 1'b0;
      tick();
    end
    rst_n_next = 1'b1;
    run_idle(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic push_one(input int p, input ent_t e);
    fq[p].push_back(e);
  endtask
endmodule
